rr_arb8: RTL and testbench
==========================

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter: MAX_HOLD, 15, max consecutive cycles one owner may hold the grant; legal range 1..15.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  8  per-requester request; bit i = requester i; level-sensitive.
REQ-005 en  input  1  arbitration enable; gates new grants only.
REQ-006 gnt  output  8  registered one-hot grant; all-zero when no owner.
REQ-007 gnt_valid  output  1  registered; high iff gnt is non-zero.
REQ-008 gnt_id  output  3  registered binary index of the granted bit; 0 when gnt_valid low.
REQ-009 timeout  output  1  registered one-cycle pulse when a grant is force-revoked.

Function
REQ-010 The block SHALL have exactly two states: IDLE (no owner) and BUSY (owner holds gnt).
REQ-011 The block SHALL keep a 3-bit priority pointer ptr; priority order SHALL be ptr, ptr-1, ..., ptr-7 (mod 8), first in order highest.
REQ-012 In IDLE with en=1 and req!=0 at edge N, the block SHALL select the highest-priority set req bit, enter BUSY, and present gnt/gnt_valid/gnt_id from cycle N+1 (1-cycle latency).
REQ-013 In IDLE with en=0 or req=0, the block SHALL remain in IDLE with gnt=0.
REQ-014 In BUSY, gnt SHALL remain stable while req[owner]=1 and the hold limit is not reached; changes on other req bits SHALL have no effect.
REQ-015 In BUSY, en SHALL be ignored; deasserting en SHALL NOT revoke an active grant.
REQ-016 A 4-bit hold counter SHALL load 0 on entry to BUSY and increment once per BUSY cycle.
REQ-017 If req[owner]=0 sampled in BUSY, the block SHALL clear gnt on the next cycle, set ptr to owner-1 (mod 8), and return to IDLE; timeout SHALL stay 0.
REQ-018 If req[owner]=1 and hold counter equals MAX_HOLD-1, the block SHALL clear gnt on the next cycle, pulse timeout high for that single cycle, set ptr to owner-1 (mod 8), and return to IDLE; gnt is therefore high for exactly MAX_HOLD cycles.
REQ-019 If release (REQ-017) and limit (REQ-018) coincide in the same cycle, release SHALL take precedence and timeout SHALL stay 0.
REQ-020 Every return from BUSY to IDLE SHALL produce exactly one cycle with gnt=0 (bus turnaround) before any new grant.
REQ-021 ptr SHALL change only on BUSY-to-IDLE transitions; wrap from 0 SHALL yield 7.
REQ-022 gnt SHALL never have more than one bit set; gnt_id SHALL always equal the index of the set bit.
REQ-023 A force-revoked owner still requesting SHALL compete normally in the next IDLE cycle under the updated ptr.

Reset
REQ-024 With reset=1 sampled at an edge, on the next cycle gnt=8'h00, gnt_valid=0, gnt_id=0, timeout=0, hold counter=0, ptr=7, state=IDLE.
REQ-025 Reset SHALL override any in-progress grant or timeout, and req/en SHALL be ignored in any cycle where reset=1.

Verification
REQ-026 Reset, then req=8'h81, en=1 -> next cycle gnt=8'h80, gnt_id=7, gnt_valid=1.
REQ-027 Continue: drop req[7] (req=8'h01) -> one cycle gnt=8'h00, then gnt=8'h01, gnt_id=0; ptr=6 after the release.
REQ-028 req=8'hFF held, each owner drops its bit for one cycle after 2 grant cycles then reasserts -> grant sequence 7,6,5,4,3,2,1,0,7 with one idle cycle between grants.
REQ-029 MAX_HOLD=15, req=8'h04 held -> gnt=8'h04 for exactly 15 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=8'h04 again.
REQ-030 en=0 with req=8'h10 -> gnt stays 0; en=1 -> grant 8'h10 next cycle; en=0 during BUSY -> gnt held until release.
REQ-031 reset=1 mid-grant (gnt=8'h20, hold counter=5) -> next cycle all outputs 0, ptr=7; with req=8'h21 after reset -> gnt=8'h20.

Source files
------------

// File: rtl/rr_arb8_if.sv
// rtl/rr_arb8_if.sv - request/grant bundle between requesters and the 8-way round-robin arbiter
interface rr_arb8_if;
    logic [7:0] req;
    logic       en;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic       timeout;

    modport master (
        output req,
        output en,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout
    );

    modport slave (
        input  req,
        input  en,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout
    );
endinterface

// File: rtl/rr_arb8.sv
// rtl/rr_arb8.sv - 8-way round-robin arbiter with descending priority pointer and hold-limit revoke
module rr_arb8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic      clock,
    input  logic      reset,
    rr_arb8_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] ptr;
    logic [2:0] ptr_nx;
    logic [2:0] owner;
    logic [2:0] owner_nx;
    logic [3:0] hold_cnt;
    logic [3:0] hold_nx;

    logic [7:0] gnt_q;
    logic [7:0] gnt_nx;
    logic       valid_q;
    logic       valid_nx;
    logic [2:0] id_q;
    logic [2:0] id_nx;
    logic       tmo_q;
    logic       tmo_nx;

    logic [2:0] win_idx;
    logic       any_req;
    logic       owner_release;
    logic       hold_limit;

    assign any_req       = |bus.req;
    assign owner_release = ~bus.req[owner];
    assign hold_limit    = (hold_cnt == HOLD_LAST);

    // Scan lowest priority first so the last hit (ptr itself) wins.
    always_comb begin
        win_idx = ptr;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[ptr - 3'(k)]) begin
                win_idx = ptr - 3'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 3'd7;
            owner    <= 3'd0;
            hold_cnt <= 4'd0;
            gnt_q    <= 8'h00;
            valid_q  <= 1'b0;
            id_q     <= 3'd0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            owner    <= owner_nx;
            hold_cnt <= hold_nx;
            gnt_q    <= gnt_nx;
            valid_q  <= valid_nx;
            id_q     <= id_nx;
            tmo_q    <= tmo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.en && any_req) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (owner_release || hold_limit) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and the arbitration bookkeeping.
    always_comb begin
        ptr_nx   = ptr;
        owner_nx = owner;
        hold_nx  = hold_cnt;
        gnt_nx   = 8'h00;
        valid_nx = 1'b0;
        id_nx    = 3'd0;
        tmo_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (state_nx == BUSY) begin
                    owner_nx = win_idx;
                    hold_nx  = 4'd0;
                    gnt_nx   = 8'h01 << win_idx;
                    valid_nx = 1'b1;
                    id_nx    = win_idx;
                end
            end
            BUSY: begin
                if (state_nx == IDLE) begin
                    // A release in the limit cycle is an ordinary release, not a revoke.
                    ptr_nx  = owner - 3'd1;
                    hold_nx = 4'd0;
                    tmo_nx  = ~owner_release;
                end else begin
                    hold_nx  = hold_cnt + 4'd1;
                    gnt_nx   = gnt_q;
                    valid_nx = 1'b1;
                    id_nx    = owner;
                end
            end
            default: begin
                hold_nx = 4'd0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_id    = id_q;
    assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arb8.sv
// tb/tb_rr_arb8.sv - randomized and directed bench for rr_arb8 against a cycle-level behavioural model
module tb_rr_arb8;

    localparam int MAX_HOLD = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    rr_arb8_if bus();

    rr_arb8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 = none), number of grant cycles shown so far, pointer.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_ptr   = 7;
    bit         m_tmo   = 1'b0;
    logic [7:0] exp_gnt = 8'h00;
    logic       exp_valid = 1'b0;
    logic [2:0] exp_id = 3'd0;

    function automatic void model_step(input bit r, input logic [7:0] rq, input bit e);
        m_tmo = 1'b0;
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 7;
        end else if (m_owner < 0) begin
            if (e) begin
                for (int k = 0; k < 8; k++) begin
                    int i;
                    i = (m_ptr - k + 8) % 8;
                    if (rq[i]) begin
                        m_owner = i;
                        m_held  = 1;
                        break;
                    end
                end
            end
        end else if (!rq[m_owner]) begin
            m_ptr   = (m_owner + 7) % 8;
            m_owner = -1;
        end else if (m_held == MAX_HOLD) begin
            m_tmo   = 1'b1;
            m_ptr   = (m_owner + 7) % 8;
            m_owner = -1;
        end else begin
            m_held++;
        end
        exp_gnt   = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        exp_valid = (m_owner >= 0);
        exp_id    = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    endfunction

    task automatic step(input bit r, input logic [7:0] rq, input bit e);
        reset   = r;
        bus.req = rq;
        bus.en  = e;
        @(posedge clock);
        model_step(r, rq, e);
        #1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 8'($urandom), 1'b1);
            checks++;
            if ({bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout} !== 13'h0) begin
                errors++;
                $display("FAIL reset_outputs got %h/%b/%0d/%b want 00/0/0/0",
                         bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout);
            end
            checks++;
            if (dut.ptr !== 3'd7 || dut.hold_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_state got ptr=%0d hold=%0d want ptr=7 hold=0", dut.ptr, dut.hold_cnt);
            end
        end
    endtask

    task automatic test_basic();
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h81, 1'b1);
        checks++;
        if (bus.gnt !== 8'h80 || bus.gnt_id !== 3'd7 || bus.gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_first got %h/%0d/%b want 80/7/1", bus.gnt, bus.gnt_id, bus.gnt_valid);
        end
        step(1'b0, 8'h01, 1'b1);
        checks++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || dut.ptr !== 3'd6) begin
            errors++;
            $display("FAIL basic_turnaround got gnt=%h valid=%b ptr=%0d want 00/0/6", bus.gnt, bus.gnt_valid, dut.ptr);
        end
        step(1'b0, 8'h01, 1'b1);
        checks++;
        if (bus.gnt !== 8'h01 || bus.gnt_id !== 3'd0 || bus.gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_second got %h/%0d/%b want 01/0/1", bus.gnt, bus.gnt_id, bus.gnt_valid);
        end
    endtask

    task automatic test_rotate();
        int         seq[$];
        int         want[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        int         zero_run;
        logic [7:0] rq;
        logic [7:0] prev;
        step(1'b1, 8'h00, 1'b0);
        zero_run = 0;
        for (int n = 0; n < 200 && seq.size() < 9; n++) begin
            rq   = (m_owner >= 0 && m_held == 2) ? (8'hFF & ~(8'h01 << m_owner)) : 8'hFF;
            prev = bus.gnt;
            step(1'b0, rq, 1'b1);
            if (bus.gnt === 8'h00) begin
                zero_run++;
            end else if (bus.gnt !== prev) begin
                for (int b = 0; b < 8; b++) if (bus.gnt[b]) seq.push_back(b);
                if (seq.size() > 1) begin
                    checks++;
                    if (zero_run != 1) begin
                        errors++;
                        $display("FAIL rotate_gap got %0d idle cycles want 1", zero_run);
                    end
                end
                zero_run = 0;
            end
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= seq.size() || seq[i] != want[i]) begin
                errors++;
                $display("FAIL rotate_seq[%0d] got %0d want %0d", i, (i < seq.size()) ? seq[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int count;
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h04, 1'b1);
        count = 0;
        for (int n = 0; n < 40 && bus.gnt === 8'h04; n++) begin
            count++;
            step(1'b0, 8'h04, 1'b1);
        end
        checks++;
        if (count != MAX_HOLD || bus.gnt !== 8'h00 || bus.timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold got %0d cycles gnt=%h timeout=%b want %0d/00/1",
                     count, bus.gnt, bus.timeout, MAX_HOLD);
        end
        step(1'b0, 8'h04, 1'b1);
        checks++;
        if (bus.gnt !== 8'h04 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant got gnt=%h timeout=%b want 04/0", bus.gnt, bus.timeout);
        end
        for (int n = 0; n < MAX_HOLD - 1; n++) step(1'b0, 8'h04, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release_wins got gnt=%h timeout=%b want 00/0", bus.gnt, bus.timeout);
        end
    endtask

    task automatic test_enable();
        step(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 8'h10, 1'b0);
            checks++;
            if (bus.gnt !== 8'h00) begin
                errors++;
                $display("FAIL enable_off got gnt=%h want 00", bus.gnt);
            end
        end
        step(1'b0, 8'h10, 1'b1);
        checks++;
        if (bus.gnt !== 8'h10 || bus.gnt_id !== 3'd4) begin
            errors++;
            $display("FAIL enable_on got gnt=%h id=%0d want 10/4", bus.gnt, bus.gnt_id);
        end
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 8'h10 | 8'($urandom), 1'b0);
            checks++;
            if (bus.gnt !== 8'h10) begin
                errors++;
                $display("FAIL enable_busy_hold got gnt=%h want 10", bus.gnt);
            end
        end
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h10, 1'b0);
        checks++;
        if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL enable_release got gnt=%h timeout=%b want 00/0", bus.gnt, bus.timeout);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 6; n++) step(1'b0, 8'h20, 1'b1);
        checks++;
        if (bus.gnt !== 8'h20 || dut.hold_cnt !== 4'd5) begin
            errors++;
            $display("FAIL midreset_setup got gnt=%h hold=%0d want 20/5", bus.gnt, dut.hold_cnt);
        end
        step(1'b1, 8'h20, 1'b1);
        checks++;
        if ({bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout} !== 13'h0 || dut.ptr !== 3'd7) begin
            errors++;
            $display("FAIL midreset_clear got gnt=%h valid=%b id=%0d tmo=%b ptr=%0d want all 0, ptr 7",
                     bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout, dut.ptr);
        end
        step(1'b0, 8'h21, 1'b1);
        checks++;
        if (bus.gnt !== 8'h20 || bus.gnt_id !== 3'd5) begin
            errors++;
            $display("FAIL midreset_regrant got gnt=%h id=%0d want 20/5", bus.gnt, bus.gnt_id);
        end
    endtask

    task automatic test_random();
        logic [7:0] rq;
        bit         r;
        bit         e;
        int         bad;
        step(1'b1, 8'h00, 1'b0);
        rq  = 8'h00;
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) rq = 8'($urandom) & 8'($urandom);
            step(r, rq, e);
            checks++;
            if ({bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout, dut.ptr} !==
                {exp_gnt, exp_valid, exp_id, m_tmo, 3'(m_ptr)} || $countones(bus.gnt) > 1) begin
                errors++;
                if (bad < 10) begin
                    $display("FAIL random[%0d] got gnt=%h v=%b id=%0d tmo=%b ptr=%0d want gnt=%h v=%b id=%0d tmo=%b ptr=%0d",
                             n, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout, dut.ptr,
                             exp_gnt, exp_valid, exp_id, m_tmo, m_ptr);
                end
                bad++;
            end
        end
    endtask

    initial begin
        bus.req = 8'h00;
        bus.en  = 1'b0;
        test_reset();
        test_basic();
        test_rotate();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
